// File: rtl/delay_arbiter_pkg.sv
// delay_arb_pkg
//   Shared definitions for delay_arbiter: default parameter values, the
//   requester-ID width helper and the round-robin pick function.
//   No ports (package).
package delay_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CLK_DEL = 4;
    localparam int DEF_MAX_OUT = 2;

    // rr_pick works on a fixed-width vector so it can live in a package;
    // callers zero-extend their eligibility vector and truncate the grant.
    // N_REQ must therefore not exceed MAX_REQ.
    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    // A single requester still needs a 1-bit ID field in the pipeline word.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot grant on the first eligible index at or after ptr, searching
    // upward and wrapping modulo n. All zeros when nothing is eligible.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] eligible,
                                                   input int                  ptr,
                                                   input int                  n);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                // ptr < n and k < n, so one subtraction is enough to wrap
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && eligible[idx[MAX_REQ_W-1:0]]) begin
                    grant[idx[MAX_REQ_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/delay_arbiter_delay.sv
// delay_arbiter_delay
//   Fixed-latency delay line: din appears on dout CLK_DEL cycles later.
//   Synchronous active-low reset zeroes every stage.
// Ports:
//   clk      posedge clock
//   rst_n    synchronous active-low reset
//   din      word entering stage 0
//   dout     word leaving the last stage
//   msb_any  OR of the MSB of every stage (callers pack a valid flag there)
module delay_arbiter_delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             msb_any
);

    logic [WIDTH-1:0] stage [CLK_DEL];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[CLK_DEL-1];

    always_comb begin
        msb_any = 1'b0;
        for (int i = 0; i < CLK_DEL; i++) begin
            msb_any = msb_any | stage[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// delay_arbiter
//   Shares one fixed-latency delay pipeline between N_REQ requesters.
//   A round-robin arbiter accepts at most one beat per cycle, tags it with
//   its requester ID and pushes it into the delay line; at the tail the beat
//   is steered back to its owner. Each requester may have at most MAX_OUT
//   beats in flight.
// Ports:
//   clk        posedge clock
//   rst_n      synchronous active-low reset
//   req_valid  per-requester beat valid
//   req_data   flattened request data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot grant (accept = req_valid & req_ready)
//   rsp_valid  one-hot, beat for requester i exits this cycle
//   rsp_data   data of the exiting beat, 0 when nothing exits
//   busy       high while any beat is in flight
module delay_arbiter
    import delay_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DEL = DEF_CLK_DEL,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy
);

    localparam int IDW = id_width(N_REQ);
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int PW  = 1 + IDW + WIDTH;

    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUT);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    logic [CW-1:0]    cnt [N_REQ];
    logic [IDW-1:0]   ptr;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic             accept;
    logic [IDW-1:0]   grant_id;
    logic [WIDTH-1:0] grant_data;

    logic [PW-1:0]    pipe_in;
    logic [PW-1:0]    pipe_out;
    logic             pipe_busy;

    logic             tail_valid;
    logic [IDW-1:0]   tail_id;
    logic [WIDTH-1:0] tail_data;

    logic             cnt_busy;

    // Eligibility uses only the registered count, so a beat retiring this
    // cycle frees its slot from the next cycle on. Grants are forced low
    // while reset is held so nothing is offered during reset.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (cnt[i] < CNT_MAX);
        end
        grant = rst_n ? N_REQ'(rr_pick(MAX_REQ'(eligible), int'(ptr), N_REQ)) : '0;
    end

    assign req_ready = grant;
    assign accept    = |grant;

    // Encode the one-hot grant and select the winning beat's data.
    always_comb begin
        grant_id   = '0;
        grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id   = IDW'(i);
                grant_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Bubbles enter as all-zero words; the pipeline never stalls.
    assign pipe_in = {accept, grant_id, grant_data};

    delay_arbiter_delay #(
        .WIDTH   (PW),
        .CLK_DEL (CLK_DEL)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (pipe_in),
        .dout    (pipe_out),
        .msb_any (pipe_busy)
    );

    assign {tail_valid, tail_id, tail_data} = pipe_out;

    // Tail decode back to the owning requester.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid[i] = rst_n && tail_valid && (tail_id == IDW'(i));
        end
        rsp_data = (rst_n && tail_valid) ? tail_data : '0;
    end

    always_comb begin
        cnt_busy = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_busy = cnt_busy | (cnt[i] != '0);
        end
    end

    assign busy = rst_n && (pipe_busy || cnt_busy);

    // Round-robin pointer moves just past the winner; outstanding counters
    // go up on accept and down on retire, unchanged when both coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && !rsp_valid[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!grant[i] && rsp_valid[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    // Eligibility and ordered retirement make these unreachable.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                assert (!(grant[i] && !rsp_valid[i] && (cnt[i] == CNT_MAX)));
                assert (!(rsp_valid[i] && !grant[i] && (cnt[i] == '0)));
            end
        end
    end

endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter
//   Self-checking bench for delay_arbiter. Directed scenarios plus a long
//   randomized run, all compared against a queue-based reference model.
//   A second instance (CLK_DEL=1, MAX_OUT=1) covers the short-pipe build.
module tb_delay_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 4;
    localparam int M = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    logic [1:0]     req_valid1;
    logic [15:0]    req_data1;
    logic [1:0]     req_ready1;
    logic [1:0]     rsp_valid1;
    logic [7:0]     rsp_data1;
    logic           busy1;

    int n_checks;
    int n_fail;

    // Reference model: in-flight beats in acceptance order with exit cycle
    typedef struct {
        int         id;
        logic [7:0] data;
        int         exit_c;
    } beat_t;

    beat_t        q[$];
    int           cnt_m [N];
    int           ptr_m;
    int           cyc;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_rd;
    logic         exp_busy;

    delay_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .CLK_DEL (D),
        .MAX_OUT (M)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    delay_arbiter #(
        .N_REQ   (2),
        .WIDTH   (8),
        .CLK_DEL (1),
        .MAX_OUT (1)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid1),
        .req_data  (req_data1),
        .req_ready (req_ready1),
        .rsp_valid (rsp_valid1),
        .rsp_data  (rsp_data1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) cnt_m[i] = 0;
        ptr_m = 0;
        cyc   = 0;
    endtask

    task automatic model_expect();
        exp_ready = '0;
        exp_rv    = '0;
        exp_rd    = '0;
        exp_busy  = (q.size() != 0);
        if (!rst_n) begin
            exp_busy = 1'b0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr_m + k) % N;
            if (exp_ready == '0 && req_valid[i] && cnt_m[i] < M) exp_ready[i] = 1'b1;
        end
        if (q.size() > 0 && q[0].exit_c == cyc) begin
            exp_rv[q[0].id] = 1'b1;
            exp_rd          = q[0].data;
        end
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (exp_ready[i]) begin
                q.push_back('{i, req_data[i*W +: W], cyc + D});
                cnt_m[i]++;
                ptr_m = (i + 1) % N;
            end
        end
        if (exp_rv != '0) begin
            cnt_m[q[0].id]--;
            void'(q.pop_front());
        end
        cyc++;
    endtask

    task automatic reset_dut();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst_n      = 1'b0;
            req_valid  = '0;
            req_data   = '0;
            req_valid1 = '0;
            req_data1  = '0;
            #1 model_expect();
            @(posedge clk);
            model_commit();
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst_n      = 1'b0;
            req_valid  = 4'hF;
            req_data   = 32'h1234_5678;
            req_valid1 = 2'b11;
            #1 model_expect();
            n_checks++;
            if (req_ready !== 4'b0 || req_ready1 !== 2'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_ready: got %b/%b expected 0", req_ready, req_ready1);
            end
            n_checks++;
            if (rsp_valid !== 4'b0 || rsp_data !== 8'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_rsp: got %b/%h expected 0/0", rsp_valid, rsp_data);
            end
            n_checks++;
            if (busy !== 1'b0 || busy1 !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_busy: got %b/%b expected 0", busy, busy1);
            end
            @(posedge clk);
            model_commit();
        end
    endtask

    task automatic test_single_beat();
        logic [3:0] er, ev;
        logic [7:0] ed;
        logic       eb;
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rst_n     = 1'b1;
            req_valid = (c == 0) ? 4'b0010 : 4'b0000;
            req_data  = (c == 0) ? 32'h0000_A500 : 32'h0;
            #1 model_expect();
            er = (c == 0) ? 4'b0010 : 4'b0000;
            ev = (c == 4) ? 4'b0010 : 4'b0000;
            ed = (c == 4) ? 8'hA5 : 8'h00;
            eb = (c >= 1 && c <= 4);
            n_checks++;
            if (req_ready !== er) begin
                n_fail++;
                $display("[TB] FAIL single_ready c%0d: got %b expected %b", c, req_ready, er);
            end
            n_checks++;
            if (rsp_valid !== ev || rsp_data !== ed) begin
                n_fail++;
                $display("[TB] FAIL single_rsp c%0d: got %b/%h expected %b/%h", c, rsp_valid, rsp_data, ev, ed);
            end
            n_checks++;
            if (busy !== eb) begin
                n_fail++;
                $display("[TB] FAIL single_busy c%0d: got %b expected %b", c, busy, eb);
            end
            @(posedge clk);
            model_commit();
        end
    endtask

    task automatic test_all_valid();
        logic [3:0] er, ev;
        logic [7:0] ed;
        reset_dut();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst_n     = 1'b1;
            req_valid = 4'b1111;
            req_data  = {8'd3, 8'd2, 8'd1, 8'd0};
            #1 model_expect();
            er = 4'b0001 << (c % 4);
            ev = (c >= 4) ? (4'b0001 << ((c - 4) % 4)) : 4'b0000;
            ed = (c >= 4) ? 8'((c - 4) % 4) : 8'h00;
            n_checks++;
            if (req_ready !== er) begin
                n_fail++;
                $display("[TB] FAIL allvalid_ready c%0d: got %b expected %b", c, req_ready, er);
            end
            n_checks++;
            if (rsp_valid !== ev || rsp_data !== ed) begin
                n_fail++;
                $display("[TB] FAIL allvalid_rsp c%0d: got %b/%h expected %b/%h", c, rsp_valid, rsp_data, ev, ed);
            end
            @(posedge clk);
            model_commit();
        end
    endtask

    task automatic test_single_requester();
        logic [3:0] er, ev;
        logic [7:0] ed;
        reset_dut();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            rst_n     = 1'b1;
            req_valid = 4'b0100;
            req_data  = 32'h0077_0000;
            #1 model_expect();
            er = (c == 0 || c == 1 || c == 5 || c == 6 || c == 10 || c == 11) ? 4'b0100 : 4'b0000;
            ev = (c == 4 || c == 5 || c == 9 || c == 10) ? 4'b0100 : 4'b0000;
            ed = (ev != 4'b0) ? 8'h77 : 8'h00;
            n_checks++;
            if (req_ready !== er) begin
                n_fail++;
                $display("[TB] FAIL limit_ready c%0d: got %b expected %b", c, req_ready, er);
            end
            n_checks++;
            if (rsp_valid !== ev || rsp_data !== ed) begin
                n_fail++;
                $display("[TB] FAIL limit_rsp c%0d: got %b/%h expected %b/%h", c, rsp_valid, rsp_data, ev, ed);
            end
            @(posedge clk);
            model_commit();
        end
    endtask

    task automatic test_reset_midflight();
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rst_n     = (c == 2) ? 1'b0 : 1'b1;
            req_valid = (c <= 2) ? 4'b0001 : ((c == 9) ? 4'b1001 : 4'b0000);
            req_data  = 32'h0000_003C;
            #1 model_expect();
            if (c == 1) begin
                n_checks++;
                if (req_ready !== 4'b0001) begin
                    n_fail++;
                    $display("[TB] FAIL midreset_pre c%0d: got %b expected 0001", c, req_ready);
                end
            end
            if (c >= 3) begin
                n_checks++;
                if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL midreset_flush c%0d: got rsp %b busy %b expected 0/0", c, rsp_valid, busy);
                end
            end
            if (c == 9) begin
                n_checks++;
                if (req_ready !== 4'b0001) begin
                    n_fail++;
                    $display("[TB] FAIL midreset_ptr: got %b expected 0001", req_ready);
                end
            end
            @(posedge clk);
            model_commit();
        end
    endtask

    task automatic test_pointer_wrap();
        logic [3:0] vals [4];
        logic [3:0] exps [4];
        vals = '{4'b0010, 4'b1001, 4'b0001, 4'b0011};
        exps = '{4'b0010, 4'b1000, 4'b0001, 4'b0010};
        reset_dut();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst_n     = 1'b1;
            req_valid = vals[c];
            req_data  = 32'hDDCC_BBAA;
            #1 model_expect();
            n_checks++;
            if (req_ready !== exps[c]) begin
                n_fail++;
                $display("[TB] FAIL wrap_ready c%0d: got %b expected %b", c, req_ready, exps[c]);
            end
            @(posedge clk);
            model_commit();
        end
    endtask

    task automatic test_short_delay();
        logic [1:0] er, ev;
        logic [7:0] ed;
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rst_n      = 1'b1;
            req_valid  = '0;
            req_valid1 = 2'b01;
            req_data1  = {8'h00, 8'(8'h50 + c / 2)};
            #1 model_expect();
            er = (c % 2 == 0) ? 2'b01 : 2'b00;
            ev = (c % 2 == 1) ? 2'b01 : 2'b00;
            ed = (c % 2 == 1) ? 8'(8'h50 + (c - 1) / 2) : 8'h00;
            n_checks++;
            if (req_ready1 !== er) begin
                n_fail++;
                $display("[TB] FAIL short_ready c%0d: got %b expected %b", c, req_ready1, er);
            end
            n_checks++;
            if (rsp_valid1 !== ev || rsp_data1 !== ed) begin
                n_fail++;
                $display("[TB] FAIL short_rsp c%0d: got %b/%h expected %b/%h", c, rsp_valid1, rsp_data1, ev, ed);
            end
            @(posedge clk);
            model_commit();
        end
        req_valid1 = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] last_ready;
        logic [N-1:0] mask;
        logic         was_reset;
        reset_dut();
        last_ready = '0;
        was_reset  = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            // Narrow the active set for a while so the in-flight limit binds
            mask = (c >= 300 && c < 450) ? 4'b0011 : 4'b1111;
            for (int i = 0; i < N; i++) begin
                // Unaccepted beats must be held stable
                if (was_reset || !req_valid[i] || last_ready[i]) begin
                    req_valid[i]      = mask[i] && ($urandom % 3 != 0);
                    req_data[i*W +: W] = 8'($urandom);
                end
            end
            rst_n = ((c % 150) == 149) ? 1'b0 : 1'b1;
            #1 model_expect();
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("[TB] FAIL rand_ready c%0d: got %b expected %b", c, req_ready, exp_ready);
            end
            n_checks++;
            if (rsp_valid !== exp_rv) begin
                n_fail++;
                $display("[TB] FAIL rand_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_rv);
            end
            n_checks++;
            if (rsp_data !== exp_rd) begin
                n_fail++;
                $display("[TB] FAIL rand_rsp_data c%0d: got %h expected %h", c, rsp_data, exp_rd);
            end
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL rand_busy c%0d: got %b expected %b", c, busy, exp_busy);
            end
            last_ready = exp_ready;
            was_reset  = !rst_n;
            @(posedge clk);
            model_commit();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_valid1 = '0;
        req_data1  = '0;
        model_reset();
        exp_ready  = '0;
        exp_rv     = '0;
        exp_rd     = '0;
        exp_busy   = 1'b0;

        test_reset();
        test_single_beat();
        test_all_valid();
        test_single_requester();
        test_reset_midflight();
        test_pointer_wrap();
        test_short_delay();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_arbiter.md
Name: delay_arbiter

Overview:
- Shares one fixed-latency delay pipeline between N_REQ requesters.
- Round-robin arbitration picks at most one beat per cycle. Each beat is pushed into a CLK_DEL-stage delay line together with a valid bit and its requester ID.
- At the tail, the beat is steered back to its owner.
- A per-requester outstanding-beat limit (MAX_OUT) stops any one requester from filling the pipeline.

Parameters:
- N_REQ, 4, number of requesters (>=1).
- WIDTH, 8, data width per beat.
- CLK_DEL, 4, pipeline latency in clock cycles (>=1).
- MAX_OUT, 2, maximum in-flight beats per requester (>=1).

Ports:
- clk  in  1  posedge clock.
- rst_n  in  1  reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*WIDTH  flattened request data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  one-hot grant; beat i is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  N_REQ  one-hot; the beat for requester i exits the pipeline this cycle.
- rsp_data  out  WIDTH  data of the exiting beat; 0 when rsp_valid == 0.
- busy  out  1  high while any beat is in flight.

Interface note (already decided): reset rst_n, synchronous, active-low; clock clk.

Behaviour:
- Reset (synchronous, while rst_n == 0):
  - All pipeline stages cleared, so valid bits are 0.
  - Outstanding counters = 0; RR pointer = 0.
  - Outputs: req_ready = 0, rsp_valid = 0, rsp_data = 0, busy = 0.
- Eligibility: requester i is eligible when req_valid[i] == 1 and cnt[i] < MAX_OUT.
  - cnt[i] is the registered count only; a response retiring in the same cycle does not make i eligible until the next cycle.
- Arbitration (combinational within the cycle):
  - Search for the first eligible index starting at the pointer, ascending, wrapping modulo N_REQ.
  - req_ready is one-hot on that index, or all zeros if nothing is eligible.
  - req_ready does not depend on req_ready.
  - req_ready[i] may be 1 only when req_valid[i] == 1.
- Pointer: on acceptance of index g, pointer <= (g+1) mod N_REQ; with no acceptance the pointer holds.
- Issue: stage 0 captures {1, g, req_data[g]} on an accept cycle, else {0, 0, 0} (a bubble). The pipeline never stalls.
- Latency: a beat accepted at the edge closing cycle t produces rsp_valid[g] = 1 and rsp_data = its data during cycle t+CLK_DEL, for exactly one cycle.
- Tail decode:
  - rsp_valid = tail.valid ? (1 << tail.id) : 0.
  - rsp_data = tail.valid ? tail.data : 0.
- Counters, per requester per cycle:
  - +1 on accept; -1 on rsp_valid[i].
  - Both in the same cycle: unchanged.
  - Counter width = $clog2(MAX_OUT+1).
  - Overflow and underflow cannot occur; assert in simulation.
- busy = OR of all stage valid bits, OR any cnt != 0. The two terms are consistent by construction.
- Ordering: responses return in acceptance order, globally and per requester.
- Reset mid-operation: in-flight beats are discarded with no rsp_valid; arbitration restarts from requester 0.
- Not-ready requesters must hold req_valid and req_data stable. The arbiter does not enforce this.

Decomposition:
- Package delay_arb_pkg:
  - function id_width(n) = (n > 1) ? $clog2(n) : 1.
  - function rr_pick(eligible, ptr) returning a one-hot grant.
  - Default parameter constants.
- The pipeline is the existing delay block, instantiated with WIDTH = 1 + id_width(N_REQ) + WIDTH and CLK_DEL = CLK_DEL, carrying the packed {valid, id, data}.
  - Its synchronous zeroing reset provides the valid-bit clear.
- Arbiter, counters and tail decode stay in delay_arbiter.

Test Plan (defaults N_REQ=4, WIDTH=8, CLK_DEL=4, MAX_OUT=2; cycle 0 is the first cycle after reset release):
1. req_valid = 4'b0010, req_data[1] = 8'hA5 in cycle 0 only -> req_ready = 4'b0010 in cycle 0; cycle 4: rsp_valid = 4'b0010, rsp_data = 8'hA5; all other cycles rsp_valid = 0, rsp_data = 0.
2. All four valid continuously, data = requester index -> accepts in order 0,1,2,3,0,1 (one per cycle until counters saturate); rsp_valid sequence from cycle 4 follows the same order with matching data.
3. Only requester 2 valid continuously -> accepts in cycles 0,1,5,6,10,11; req_ready[2] = 0 in cycles 2-4 and 7-9; at most 2 in flight.
4. Accept requester 0 in cycles 0-1, then assert rst_n = 0 in cycle 2 -> no rsp_valid ever appears; busy = 0 from cycle 3; after release the first grant goes to requester 0 even if requester 3 is also valid.
5. Pointer at 2 (after a grant to 1), req_valid = 4'b1001 -> requester 3 granted first, then 0; the pointer ends at 1.
6. CLK_DEL = 1 build: accept in cycle t -> rsp_valid in cycle t+1; back-to-back accepts for the same requester with MAX_OUT = 1 -> accepts every 2nd cycle.
